score_display: RTL and testbench

- Reader end of the score interface: consumes the binary `score` bus driven by `score_counter` and drives a multiplexed common-anode 7-segment display.
- Detects score changes and converts them to BCD with an iterative double-dabble sequencer.
- Holds the last complete BCD result and time-multiplexes the digits at a prescaled refresh rate.

---
 rtl/score_display_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 98 +++++++++
 rtl/score_display.sv | 134 +++++++++++++
 tb/tb_score_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared definitions for the score display slice.
//   SEG_0..SEG_9, SEG_OFF : active-low segment codes, bit order gfedcba (bit0 = a).
//   state_t               : conversion sequencer states IDLE / SHIFT / DONE.
//   seg_encode()          : BCD digit to segment code; any nibble above 9 encodes as SEG_OFF.
package score_display_pkg;

   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter.
//   clk, rst : clock, asynchronous active-high reset
//   start    : in IDLE, samples value and begins a conversion
//   value    : binary input (WIDTH bits)
//   busy     : high from the sample edge until the DONE edge
//   done     : high for the single DONE cycle; bcd/sampled are valid then
//   bcd      : DIGITS BCD nibbles, saturated to all nines when value > 10^DIGITS-1
//   sampled  : the binary value this conversion was started with
module bin2bcd_seq
   import score_display_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [WIDTH-1:0]      sampled
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam longint unsigned MAX_VAL = (64'd10 ** DIGITS) - 64'd1;

   state_t                state_q, state_d;
   logic [BW+WIDTH-1:0]   sh_q, sh_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]      samp_q, samp_d;
   logic                  busy_q, busy_d;

   // Add 3 to every nibble >= 5 so the following shift carries correctly in BCD.
   function automatic logic [BW-1:0] adjust(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      for (int k = 0; k < int'(DIGITS); k++) begin
         r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      samp_d  = samp_q;
      busy_d  = busy_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = {{BW{1'b0}}, value};
               samp_d  = value;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = {adjust(sh_q[BW+WIDTH-1:WIDTH]), sh_q[WIDTH-1:0]} << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         samp_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         samp_q  <= samp_d;
         busy_q  <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign sampled = samp_q;
   // Values that cannot be shown on DIGITS digits display as all nines.
   assign bcd = (64'(samp_q) > MAX_VAL) ? {DIGITS{4'h9}} : sh_q[BW+WIDTH-1:WIDTH];

endmodule

// File: rtl/score_display.sv
// Multiplexed common-anode 7-segment score display.
//   clk, rst  : clock, asynchronous active-high reset
//   score     : binary score (WIDTH bits)
//   blank     : forces the display dark while high
//   seg       : active-low segments, bit0 = a .. bit6 = g
//   dp        : active-low decimal point, always off
//   an        : active-low digit enables, one-hot-low while lit
//   busy      : conversion in progress
//   bcd_valid : a conversion has completed since reset
// Optional: define SCORE_DISPLAY_LZB_EN for leading-zero blanking (digit 0 never blanked).
module score_display
   import score_display_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  score,
   input  logic              blank,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic              busy,
   output logic              bcd_valid
);

   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] hold_q, conv_bcd;
   logic [WIDTH-1:0]    last_q, conv_val;
   logic                valid_q, conv_done, start;
   logic [PW-1:0]       presc_q;
   logic [IW-1:0]       idx_q;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [DIGITS-1:0]   lz;
   logic [3:0]          digit;
   logic                digit_lz;

   // Only consulted in IDLE, so changes during a conversion are picked up afterwards.
   assign start = !valid_q || (score != last_q);

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .value   (score),
      .busy    (busy),
      .done    (conv_done),
      .bcd     (conv_bcd),
      .sampled (conv_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q  <= '0;
         last_q  <= '0;
         valid_q <= 1'b0;
      end else if (conv_done) begin
         hold_q  <= conv_bcd;
         last_q  <= conv_val;
         valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

`ifdef SCORE_DISPLAY_LZB_EN
   // lz[k] marks digits above 0 whose nibble and all higher nibbles are zero.
   always_comb begin
      logic nz;
      nz = 1'b0;
      lz = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         nz    = nz | (hold_q[4*k +: 4] != 4'd0);
         lz[k] = (k != 0) && !nz;
      end
   end
`else
   assign lz = '0;
`endif

   always_comb begin
      seg_d    = SEG_OFF;
      an_d     = '1;
      digit    = '0;
      digit_lz = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (IW'(k) == idx_q) begin
            digit    = hold_q[4*k +: 4];
            digit_lz = lz[k];
         end
      end
      if (valid_q && !blank) begin
         for (int k = 0; k < int'(DIGITS); k++) begin
            an_d[k] = (IW'(k) != idx_q);
         end
         seg_d = digit_lz ? SEG_OFF : seg_encode(digit);
      end
   end

   // seg and an share one register so a digit switch never shows the neighbour's pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= SEG_OFF;
         an_q  <= '1;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign dp        = 1'b1;
   assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with WIDTH=8, DIGITS=3, REFRESH_DIV=4.
// Expected display values are queued when a score is driven and popped when checked.
module tb_score_display;

   localparam int unsigned RDIV = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic       clk, rst, blank, dp, busy, bcd_valid;
   logic [7:0] score;
   logic [6:0] seg;
   logic [2:0] an;

   int total = 0;
   int bad   = 0;
   int n_edges;
   int exp_q[$];

   score_display #(
      .WIDTH       (8),
      .DIGITS      (3),
      .REFRESH_DIV (RDIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .score     (score),
      .blank     (blank),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .busy      (busy),
      .bcd_valid (bcd_valid)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the lit digit after edge n is ((n-1)/RDIV) % 3.
   always @(posedge clk or posedge rst) begin
      if (rst) n_edges <= 0;
      else     n_edges <= n_edges + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int val, input int k);
      int p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
`ifdef SCORE_DISPLAY_LZB_EN
      if (k > 0 && val < p) return 7'h7F;
`endif
      return SEG_TAB[(val / p) % 10];
   endfunction

   // Waits (bounded) for busy, then returns how many sampled cycles it stayed high.
   task automatic run_conv(output int cyc);
      int guard;
      guard = 0;
      cyc   = 0;
      while (busy !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("busy_rise", {31'd0, busy}, 32'd1);
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic check_display(input string tag, input int cycles);
      int         val, k;
      logic [2:0] ea;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_queue got=empty exp=entry", tag);
         return;
      end
      val = exp_q.pop_front();
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         k  = ((n_edges - 1) / RDIV) % 3;
         ea = ~(3'b001 << k);
         chk({tag, "_an"}, {29'd0, an}, {29'd0, ea});
         chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg(val, k)});
      end
   endtask

   initial begin
      int cyc;
      clk   = 1'b0;
      rst   = 1'b1;
      score = 8'd0;
      blank = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_seg",   {25'd0, seg}, 32'h7F);
      chk("rst_an",    {29'd0, an}, 32'h7);
      chk("rst_dp",    {31'd0, dp}, 32'd1);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, bcd_valid}, 32'd0);

      // First conversion after reset, score 0.
      rst = 1'b0;
      exp_q.push_back(0);
      run_conv(cyc);
      chk("conv0_cycles", cyc, 32'd9);
      chk("conv0_valid", {31'd0, bcd_valid}, 32'd1);
      chk("conv0_dark_an", {29'd0, an}, 32'h7);
      chk("conv0_dark_seg", {25'd0, seg}, 32'h7F);
      check_display("disp0", 13);

      score = 8'd99;
      exp_q.push_back(99);
      run_conv(cyc);
      chk("conv99_cycles", cyc, 32'd9);
      check_display("disp99", 13);

      // Change 5 -> 7 while the conversion of 5 is running.
      score = 8'd5;
      exp_q.push_back(5);
      @(negedge clk);
      @(negedge clk);
      chk("busy_mid", {31'd0, busy}, 32'd1);
      score = 8'd7;
      exp_q.push_back(7);
      run_conv(cyc);
      chk("conv5_cycles", cyc, 32'd8);
      check_display("disp5", 8);
      // 9 busy cycles in total, 7 of them consumed by the display check above.
      run_conv(cyc);
      chk("conv7_tail", cyc, 32'd2);
      check_display("disp7", 13);

      score = 8'd255;
      exp_q.push_back(255);
      run_conv(cyc);
      chk("conv255_cycles", cyc, 32'd9);
      check_display("disp255", 13);

      // Blanking mid-scan; scan timing must continue underneath.
      blank = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("blank_an", {29'd0, an}, 32'h7);
         chk("blank_seg", {25'd0, seg}, 32'h7F);
      end
      blank = 1'b0;
      exp_q.push_back(255);
      check_display("unblank", 8);

      // Reset in the middle of SHIFT.
      score = 8'd42;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_an", {29'd0, an}, 32'h7);
      chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, bcd_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(42);
      run_conv(cyc);
      chk("conv42_cycles", cyc, 32'd9);
      chk("conv42_valid", {31'd0, bcd_valid}, 32'd1);
      check_display("disp42", 13);
      chk("final_dp", {31'd0, dp}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
